// File: rtl/mtx_arb_pkg.sv
// rtl/mtx_arb_pkg.sv - shared types and helpers for the matrix arbiter family
package mtx_arb_pkg;

   // Largest supported requester count; sets the width of the shared helpers.
   localparam int MAX_N  = 32;
   localparam int MAX_IW = 5;

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_t;

   // Binary index of a one-hot vector; an all-zero vector encodes to 0.
   function automatic logic [MAX_IW-1:0] onehot2bin(input logic [MAX_N-1:0] oh);
      logic [MAX_IW-1:0] bin;
      bin = '0;
      for (int i = 0; i < MAX_N; i++) begin
         if (oh[i]) bin = bin | MAX_IW'(i);
      end
      return bin;
   endfunction

endpackage

// File: rtl/mtx_arb_pick.sv
// rtl/mtx_arb_pick.sv - combinational winner pick over a precedence matrix
module mtx_arb_pick
   import mtx_arb_pkg::*;
#(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]        cand,
   input  logic [N-1:0][N-1:0] w,
   output logic [N-1:0]        win_oh,
   output logic [IW-1:0]       win_idx
);

   // A candidate wins when no other candidate has precedence over it.
   always_comb begin
      win_oh = '0;
      for (int i = 0; i < N; i++) begin
         win_oh[i] = cand[i] & ~|(cand & ~w[i] & ~(N'(1) << i));
      end
   end

   assign win_idx = IW'(onehot2bin(MAX_N'(win_oh)));

endmodule

// File: rtl/mtx_arb_pl.sv
// rtl/mtx_arb_pl.sv - priority-level matrix arbiter with burst grant locking
module mtx_arb_pl
   import mtx_arb_pkg::*;
#(
   parameter  int N  = 4,
   parameter  int PW = 2,
   localparam int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    req,
   input  logic [N*PW-1:0] req_pri,
   input  logic [N-1:0]    req_last,
   input  logic            ack,
   output logic [N-1:0]    gnt,
   output logic            gnt_vld,
   output logic [IW-1:0]   gnt_idx,
   output logic [PW-1:0]   gnt_pri
);

   state_t              state;
   logic [PW-1:0]       maxp;
   logic [N-1:0]        cand;
   logic [N-1:0]        win_oh;
   logic [IW-1:0]       win_idx;
   logic [N-1:0][N-1:0] w;
   logic                own_req;
   logic                own_last;

   // Highest priority level among active requesters, then the set sitting at it.
   always_comb begin
      maxp = '0;
      cand = '0;
      for (int i = 0; i < N; i++) begin
         if (req[i] && (req_pri[i*PW +: PW] > maxp)) maxp = req_pri[i*PW +: PW];
      end
      for (int i = 0; i < N; i++) begin
         cand[i] = req[i] && (req_pri[i*PW +: PW] == maxp);
      end
   end

   mtx_arb_pick #(.N(N), .IW(IW)) u_pick (
      .cand    (cand),
      .w       (w),
      .win_oh  (win_oh),
      .win_idx (win_idx)
   );

   // The owner is tracked through the one-hot grant, so no index decode is needed.
   assign own_req  = |(req & gnt);
   assign own_last = |(req_last & gnt);

   // Grant FSM: capture a winner in IDLE, hold it through the burst, demote on completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= ST_IDLE;
         gnt     <= '0;
         gnt_vld <= 1'b0;
         gnt_idx <= '0;
         gnt_pri <= '0;
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               w[i][j] <= (i <= j);
            end
         end
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  gnt     <= win_oh;
                  gnt_vld <= 1'b1;
                  gnt_idx <= win_idx;
                  gnt_pri <= maxp;
                  state   <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               if (!own_req) begin
                  // Owner withdrew: release without touching precedence.
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  gnt_idx <= '0;
                  gnt_pri <= '0;
                  state   <= ST_IDLE;
               end else if (ack && own_last) begin
                  gnt     <= '0;
                  gnt_vld <= 1'b0;
                  gnt_idx <= '0;
                  gnt_pri <= '0;
                  state   <= ST_IDLE;
                  // Owner loses to everyone: clear its row, set its column.
                  for (int i = 0; i < N; i++) begin
                     for (int j = 0; j < N; j++) begin
                        if (i != j) begin
                           if (gnt[i])      w[i][j] <= 1'b0;
                           else if (gnt[j]) w[i][j] <= 1'b1;
                        end
                     end
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mtx_arb_pl.sv
// tb/tb_mtx_arb_pl.sv - scoreboard bench for mtx_arb_pl (N=4 directed, N=8 stress)
module tb_mtx_arb_pl;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [3:0]  req4 = '0, last4 = '0, gnt4;
   logic [7:0]  pri4 = '0;
   logic        ack4 = 1'b0, vld4;
   logic [1:0]  idx4, gpri4;

   logic [7:0]  req8 = '0, last8 = '0, gnt8;
   logic [23:0] pri8 = '0;
   logic        ack8 = 1'b0, vld8;
   logic [2:0]  idx8, gpri8;

   typedef struct {
      int idx;
      int pri;
   } exp_t;

   exp_t q4[$];
   exp_t q8[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   mtx_arb_pl #(.N(4), .PW(2)) dut4 (
      .clk(clk), .rst(rst), .req(req4), .req_pri(pri4), .req_last(last4), .ack(ack4),
      .gnt(gnt4), .gnt_vld(vld4), .gnt_idx(idx4), .gnt_pri(gpri4)
   );

   mtx_arb_pl #(.N(8), .PW(3)) dut8 (
      .clk(clk), .rst(rst), .req(req8), .req_pri(pri8), .req_last(last8), .ack(ack8),
      .gnt(gnt8), .gnt_vld(vld8), .gnt_idx(idx8), .gnt_pri(gpri8)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push4(input int i, input int p);
      exp_t e;
      e.idx = i;
      e.pri = p;
      q4.push_back(e);
   endtask

   task automatic push8(input int i, input int p);
      exp_t e;
      e.idx = i;
      e.pri = p;
      q8.push_back(e);
   endtask

   // Monitor for the N=4 instance: compare each new grant against the scoreboard.
   logic       pv4 = 1'b0;
   logic [3:0] pg4 = '0;
   always @(negedge clk) begin
      exp_t e;
      if (vld4 && (!pv4 || gnt4 != pg4)) begin
         if (q4.size() == 0) begin
            check("gnt4_unexpected", 32'(gnt4), 32'd0);
         end else begin
            e = q4.pop_front();
            check("gnt4", 32'(gnt4), 32'd1 << e.idx);
            check("gnt4_idx", 32'(idx4), 32'(e.idx));
            check("gnt4_pri", 32'(gpri4), 32'(e.pri));
         end
      end
      check("gnt4_invariant", 32'($onehot0(gnt4) && ((gnt4 != 0) == vld4)
                                  && (vld4 || (idx4 == 0 && gpri4 == 0))), 32'd1);
      pv4 = vld4;
      pg4 = gnt4;
   end

   // Monitor for the N=8 instance, plus matrix antisymmetry.
   logic       pv8 = 1'b0;
   logic [7:0] pg8 = '0;
   always @(negedge clk) begin
      exp_t e;
      logic ok;
      if (vld8 && (!pv8 || gnt8 != pg8)) begin
         if (q8.size() == 0) begin
            check("gnt8_unexpected", 32'(gnt8), 32'd0);
         end else begin
            e = q8.pop_front();
            check("gnt8", 32'(gnt8), 32'd1 << e.idx);
            check("gnt8_idx", 32'(idx8), 32'(e.idx));
            check("gnt8_pri", 32'(gpri8), 32'(e.pri));
         end
      end
      ok = $onehot0(gnt8) && ((gnt8 != 0) == vld8);
      for (int i = 0; i < 8; i++) begin
         if (!dut8.w[i][i]) ok = 1'b0;
         for (int j = 0; j < 8; j++) begin
            if (i != j && dut8.w[i][j] == dut8.w[j][i]) ok = 1'b0;
         end
      end
      check("gnt8_invariant", 32'(ok), 32'd1);
      pv8 = vld8;
      pg8 = gnt8;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      logic [3:0][3:0] pat;
      int ord[$];
      int maxp, win, need, cnt, guard;
      logic [7:0]  r;
      logic [23:0] p;

      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++)
            pat[i][j] = (i <= j);

      // Reset state
      step();
      step();
      check("rst_gnt", 32'(gnt4), 32'd0);
      check("rst_vld", 32'(vld4), 32'd0);
      check("rst_idx", 32'(idx4), 32'd0);
      check("rst_pri", 32'(gpri4), 32'd0);
      check("rst_matrix", 32'(dut4.w), 32'(pat));
      rst = 1'b0;

      // Round robin of single-beat bursts at equal priority
      req4 = 4'hF; pri4 = '0; last4 = 4'hF; ack4 = 1'b1;
      push4(0, 0); push4(1, 0); push4(2, 0); push4(3, 0); push4(0, 0);
      repeat (10) step();
      req4 = '0; ack4 = 1'b0; last4 = '0;
      step();
      check("rr_idle", 32'(vld4), 32'd0);
      step();

      // Priority dominates the matrix
      pri4 = 8'b00_11_01_00;
      req4 = 4'b0110;
      push4(2, 3); push4(1, 1);
      step();
      ack4 = 1'b1; last4 = 4'b0100;
      step();
      req4 = 4'b0010; ack4 = 1'b0; last4 = '0;
      step();
      ack4 = 1'b1; last4 = 4'b0010;
      step();
      req4 = '0; ack4 = 1'b0; last4 = '0; pri4 = '0;
      step();

      // Multi-beat burst for owner 1, with a late request from 3
      req4 = 4'b0010;
      push4(1, 0); push4(3, 0);
      step();
      ack4 = 1'b1;
      step();
      check("burst_hold1", 32'(gnt4), 32'h2);
      ack4 = 1'b0;
      step();
      check("burst_hold2", 32'(gnt4), 32'h2);
      ack4 = 1'b1; req4 = 4'b1010;
      step();
      check("burst_hold3", 32'(gnt4), 32'h2);
      last4 = 4'b0010;
      step();
      check("burst_release", 32'(vld4), 32'd0);
      ack4 = 1'b0; last4 = '0;
      step();
      ack4 = 1'b1; last4 = 4'b1000;
      step();
      req4 = '0; ack4 = 1'b0; last4 = '0;
      step();

      // Abort by owner 2 with ack in the same cycle leaves precedence untouched
      req4 = 4'b0001; ack4 = 1'b1; last4 = 4'b0001;
      push4(0, 0);
      step();
      step();
      req4 = 4'b0100; ack4 = 1'b0; last4 = '0;
      push4(2, 0);
      step();
      req4 = '0; ack4 = 1'b1; last4 = 4'b0100;
      step();
      check("abort_release", 32'(vld4), 32'd0);
      req4 = 4'b0101; ack4 = 1'b1; last4 = 4'b0101;
      push4(2, 0); push4(0, 0);
      repeat (4) step();
      req4 = '0; ack4 = 1'b0; last4 = '0;
      step();

      // Reset during a burst restores the reset matrix
      req4 = 4'b1000;
      push4(3, 0);
      step();
      check("busy_before_rst", 32'(vld4), 32'd1);
      rst = 1'b1;
      step();
      check("midrst_gnt", 32'(gnt4), 32'd0);
      check("midrst_vld", 32'(vld4), 32'd0);
      check("midrst_matrix", 32'(dut4.w), 32'(pat));
      rst = 1'b0;
      req4 = 4'b1001; ack4 = 1'b1; last4 = 4'b1001;
      push4(0, 0); push4(3, 0);
      repeat (4) step();
      req4 = '0; ack4 = 1'b0; last4 = '0;
      step();
      step();

      // Stress on N=8: least-recently-granted list as the reference
      for (int i = 0; i < 8; i++) ord.push_back(i);
      repeat (40) begin
         r = 8'($urandom_range(1, 255));
         p = 24'($urandom);
         maxp = -1;
         for (int i = 0; i < 8; i++)
            if (r[i] && int'(p[i*3 +: 3]) > maxp) maxp = int'(p[i*3 +: 3]);
         win = -1;
         for (int k = 0; k < ord.size(); k++)
            if (win < 0 && r[ord[k]] && int'(p[ord[k]*3 +: 3]) == maxp) win = ord[k];
         push8(win, maxp);
         req8 = r; pri8 = p; ack8 = 1'b0; last8 = '0;
         step();
         check("stress_vld", 32'(vld8), 32'd1);
         need = $urandom_range(1, 3);
         cnt = 0;
         guard = 0;
         while (cnt < need && guard < 64) begin
            ack8 = 1'($urandom_range(0, 1));
            last8 = 8'($urandom);
            last8[win] = (cnt == need - 1);
            req8 = 8'($urandom) | (8'd1 << win);
            pri8 = 24'($urandom);
            step();
            if (ack8) cnt++;
            guard++;
         end
         check("stress_acks", 32'(cnt), 32'(need));
         check("stress_release", 32'(vld8), 32'd0);
         for (int k = 0; k < ord.size(); k++) begin
            if (ord[k] == win) begin
               ord.delete(k);
               break;
            end
         end
         ord.push_back(win);
         req8 = '0; ack8 = 1'b0; last8 = '0;
      end
      step();
      step();

      check("q4_drained", 32'(q4.size()), 32'd0);
      check("q8_drained", 32'(q8.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mtx_arb_pl.md
Name: mtx_arb_pl

Overview:
Parametrised matrix (least-recently-granted) arbiter with per-request priority levels and multi-beat grant locking.
- Highest requested priority level wins; ties within that level are broken by an N×N precedence matrix.
- The grant is registered and held across a burst until the owner's last beat is acknowledged.
- Sits in front of shared buses/memories where each requester transfers multi-beat bursts.

Parameters:
N, 4, number of requesters (2..32)
PW, 2, priority field width per requester; larger value = higher priority
IW, $clog2(N), grant index width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req  in  N  request per requester, level-held until burst done
req_pri  in  N*PW  priority of requester i at bits [i*PW +: PW]
req_last  in  N  requester i's current beat is its last
ack  in  1  downstream accepts the current beat of the granted requester
gnt  out  N  registered one-hot grant, 0 when idle
gnt_vld  out  1  gnt holds an owner
gnt_idx  out  IW  binary index of owner, 0 when idle
gnt_pri  out  PW  captured priority of owner, 0 when idle

Behaviour:
- Reset (rst=1 at posedge clk):
  - gnt=0, gnt_vld=0, gnt_idx=0, gnt_pri=0, FSM=IDLE.
  - Matrix w[i][j]=1 for i<j, 0 for i>j, so requester 0 has highest tie precedence.
  - Reset asserted mid-burst drops the grant immediately, with no matrix update.
- Matrix semantics:
  - w[i][j]=1 means i beats j at equal priority.
  - Diagonal is unused and held 1.
  - Antisymmetry w[i][j] = ~w[j][i] for i≠j holds at all times.
- Candidate selection (combinational, IDLE only):
  - maxp = max req_pri over requesters with req=1.
  - cand[i] = req[i] & (req_pri[i]==maxp).
  - Winner i satisfies cand[i] & ~|(cand & ~w[i] & ~onehot(i)).
  - Exactly one winner when cand≠0.
- FSM:
  - IDLE:
    - If |req, register gnt=onehot(winner), gnt_idx=winner, gnt_pri=maxp, gnt_vld=1, go BUSY.
    - Grant is visible the cycle after req is sampled: 1-cycle latency.
  - BUSY, completion: if ack & req_last[gnt_idx] & req[gnt_idx]:
    - Clear all grant outputs and go IDLE.
    - Update the matrix: for all j≠owner, w[owner][j]←0 and w[j][owner]←1, so the owner becomes lowest precedence.
  - BUSY, non-last beat: ack without req_last keeps the grant.
  - BUSY, abort: if req[gnt_idx]=0, clear the grant and go IDLE with no matrix update.
    - Abort takes precedence over ack in the same cycle.
  - BUSY, other requests: changes to other requesters' req or req_pri have no effect while BUSY.
- Throughput:
  - One mandatory IDLE bubble cycle between bursts.
  - The next arbitration uses the updated matrix.
- ack while IDLE is ignored.
- Single-beat burst: req_last=1 on the first acked beat completes in the grant's first BUSY cycle.
- gnt is never non-zero with gnt_vld=0, and never has more than one bit set.
- Priority strictly dominates; low-priority starvation under sustained high-priority traffic is permitted and documented.

Decomposition:
- Package mtx_arb_pkg:
  - state enum {ST_IDLE, ST_BUSY}
  - function onehot2bin(N-bit)
  - localparam max N = 32
- Sub-module mtx_arb_pick (combinational):
  - Inputs: cand[N], w[N][N].
  - Outputs: win_oh[N], win_idx[IW].
  - Reused by later arbiter variants.
- Top holds the priority-max reduction, FSM, grant registers and matrix registers.

Test Plan:
- Reset then req=4'b1111, all pri=0, each burst single-beat with ack=1:
  - Grant order is 0,1,2,3,0, with a gnt_vld=0 bubble between each grant.
- req=4'b0110, pri1=1, pri2=3:
  - gnt=4'b0100, gnt_pri=3, gnt_idx=2 one cycle later.
  - After completion with only req1 held, next gnt=4'b0010.
- Multi-beat burst, owner 1 with ack pulsed 3 times and req_last on the 3rd ack:
  - gnt=4'b0010 stays constant for all BUSY cycles.
  - Release occurs exactly on the 3rd ack.
  - req3 raised mid-burst gets no grant until IDLE.
- Abort, owner 2 drops req mid-burst with ack=1 same cycle:
  - Grant clears and the matrix is unchanged.
  - Re-requesting 0 and 2 at equal priority yields the same order as before the abort.
- rst=1 during BUSY:
  - Next cycle gnt=0, gnt_vld=0, matrix at reset pattern.
  - req=4'b1000|4'b0001 at equal priority grants 0 first.
- Random stress, N=8, PW=3:
  - Assert one-hot/zero gnt, matrix antisymmetry, and that grants only go to requesters of the highest priority level.
  - Assert no same-priority requester waits more than N-1 grants while at max priority.
